// File: rtl/puck_motion_if.sv
// Frame-level control and status bundle between the puck motion block and its neighbours.
interface puck_motion_if;
  logic       vsync;
  logic       hit;
  logic [5:0] hit_vx;
  logic [5:0] hit_vy;
  logic       serve;
  logic       serve_dir;
  logic [10:0] x;
  logic [9:0]  y;
  logic [5:0]  vx;
  logic [5:0]  vy;
  logic        moving;
  logic        bounce;
  logic        goal_left;
  logic        goal_right;

  modport master (
    output vsync, hit, hit_vx, hit_vy, serve, serve_dir,
    input  x, y, vx, vy, moving, bounce, goal_left, goal_right
  );

  modport slave (
    input  vsync, hit, hit_vx, hit_vy, serve, serve_dir,
    output x, y, vx, vy, moving, bounce, goal_left, goal_right
  );
endinterface

// File: rtl/puck_motion.sv
// Air-hockey puck kinematics: serve, strike velocity, wall reflection and goal detection,
// all advanced once per frame on the vsync rising edge.
module puck_motion #(
  parameter int RADIUS      = 16,
  parameter int FIELD_W     = 1024,
  parameter int FIELD_H     = 768,
  parameter int GOAL_TOP    = 256,
  parameter int GOAL_BOT    = 511,
  parameter int MAX_SPEED   = 15,
  parameter int SERVE_SPEED = 4,
  parameter int GOAL_FRAMES = 60
) (
  input logic         clock,
  input logic         reset,
  puck_motion_if.slave bus
);

  localparam int CntW = (GOAL_FRAMES > 1) ? $clog2(GOAL_FRAMES) : 1;

  localparam logic [10:0]        XHome   = 11'(FIELD_W / 2 - RADIUS);
  localparam logic [9:0]         YHome   = 10'(FIELD_H / 2 - RADIUS);
  localparam logic signed [12:0] XMax    = 13'(FIELD_W - 2 * RADIUS);
  localparam logic signed [12:0] YMax    = 13'(FIELD_H - 2 * RADIUS);
  localparam logic signed [12:0] Rad     = 13'(RADIUS);
  localparam logic signed [12:0] GoalTop = 13'(GOAL_TOP);
  localparam logic signed [12:0] GoalBot = 13'(GOAL_BOT);
  localparam logic signed [5:0]  VMax    = 6'(MAX_SPEED);
  localparam logic signed [5:0]  VServe  = 6'(SERVE_SPEED);
  localparam logic [CntW-1:0]    CntLast = CntW'(GOAL_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StMoving, StGoal} state_e;

  state_e             state_q, state_d;
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic signed [5:0]  vx_q, vx_d, vy_q, vy_d;
  logic               pend_q, pend_d;
  logic signed [5:0]  pvx_q, pvx_d, pvy_q, pvy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               vsync_q;
  logic               bounce_q, bounce_d;
  logic               goal_left_q, goal_left_d;
  logic               goal_right_q, goal_right_d;

  logic               ft;
  logic signed [5:0]  hit_vx_c, hit_vy_c, nvx, nvy;
  logic signed [12:0] nx, ny, ry, cy;
  logic               x_ref, y_ref, in_mouth;

  function automatic logic signed [5:0] clamp_v(input logic signed [5:0] v);
    if (v > VMax) begin
      return VMax;
    end else if (v < -VMax) begin
      return -VMax;
    end
    return v;
  endfunction

  assign ft       = bus.vsync & ~vsync_q;
  assign hit_vx_c = clamp_v($signed(bus.hit_vx));
  assign hit_vy_c = clamp_v($signed(bus.hit_vy));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    pend_d       = pend_q;
    pvx_d        = pvx_q;
    pvy_d        = pvy_q;
    cnt_d        = cnt_q;
    bounce_d     = 1'b0;
    goal_left_d  = 1'b0;
    goal_right_d = 1'b0;
    nvx          = vx_q;
    nvy          = vy_q;
    nx           = '0;
    ny           = '0;
    ry           = '0;
    cy           = '0;
    x_ref        = 1'b0;
    y_ref        = 1'b0;
    in_mouth     = 1'b0;

    unique case (state_q)
      StIdle: begin
        x_d  = XHome;
        y_d  = YHome;
        vx_d = '0;
        vy_d = '0;
        if (ft && bus.serve) begin
          state_d = StMoving;
          vx_d    = bus.serve_dir ? VServe : -VServe;
        end
      end

      StMoving: begin
        if (ft) begin
          // A same-cycle strike beats whatever is still waiting in the slot.
          nvx    = bus.hit ? hit_vx_c : (pend_q ? pvx_q : vx_q);
          nvy    = bus.hit ? hit_vy_c : (pend_q ? pvy_q : vy_q);
          pend_d = 1'b0;
          nx     = $signed({2'b00, x_q}) + 13'(nvx);
          ny     = $signed({3'b000, y_q}) + 13'(nvy);

          if (ny < 13'sd0) begin
            ry    = '0;
            y_ref = 1'b1;
          end else if (ny > YMax) begin
            ry    = YMax;
            y_ref = 1'b1;
          end else begin
            ry = ny;
          end
          cy       = ry + Rad;
          in_mouth = (cy >= GoalTop) && (cy <= GoalBot);

          x_d  = nx[10:0];
          y_d  = ry[9:0];
          vx_d = nvx;
          vy_d = y_ref ? -nvy : nvy;

          if (nx < 13'sd0 || nx > XMax) begin
            if (in_mouth) begin
              // Puck stays where it was last drawn while the goal is celebrated.
              state_d      = StGoal;
              x_d          = x_q;
              y_d          = y_q;
              vx_d         = '0;
              vy_d         = '0;
              cnt_d        = '0;
              goal_left_d  = nx[12];
              goal_right_d = ~nx[12];
              y_ref        = 1'b0;
            end else begin
              x_ref = 1'b1;
              x_d   = nx[12] ? 11'd0 : XMax[10:0];
              vx_d  = -nvx;
            end
          end
          bounce_d = x_ref | y_ref;
        end else if (bus.hit) begin
          pend_d = 1'b1;
          pvx_d  = hit_vx_c;
          pvy_d  = hit_vy_c;
        end
      end

      StGoal: begin
        vx_d = '0;
        vy_d = '0;
        if (ft) begin
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            x_d     = XHome;
            y_d     = YHome;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      x_q          <= XHome;
      y_q          <= YHome;
      vx_q         <= '0;
      vy_q         <= '0;
      pend_q       <= 1'b0;
      pvx_q        <= '0;
      pvy_q        <= '0;
      cnt_q        <= '0;
      vsync_q      <= 1'b0;
      bounce_q     <= 1'b0;
      goal_left_q  <= 1'b0;
      goal_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      pend_q       <= pend_d;
      pvx_q        <= pvx_d;
      pvy_q        <= pvy_d;
      cnt_q        <= cnt_d;
      vsync_q      <= bus.vsync;
      bounce_q     <= bounce_d;
      goal_left_q  <= goal_left_d;
      goal_right_q <= goal_right_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.vx         = vx_q;
  assign bus.vy         = vy_q;
  assign bus.moving     = (state_q == StMoving);
  assign bus.bounce     = bounce_q;
  assign bus.goal_left  = goal_left_q;
  assign bus.goal_right = goal_right_q;

endmodule

// File: tb/tb_puck_motion.sv
// Directed scenarios followed by random play, all checked against a frame-rule model.
module tb_puck_motion;
  localparam int XHome = 1024 / 2 - 16;
  localparam int YHome = 768 / 2 - 16;
  localparam int XLim  = 1024 - 32;
  localparam int YLim  = 768 - 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  puck_motion_if bus ();

  puck_motion dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: 0 idle, 1 moving, 2 goal.
  int m_state, m_x, m_y, m_vx, m_vy, m_pvx, m_pvy, m_cnt;
  bit m_pend, m_vs, m_b, m_gl, m_gr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sv(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampv(input logic [5:0] raw);
    int v;
    v = sv(raw);
    if (v > 15) return 15;
    if (v < -15) return -15;
    return v;
  endfunction

  task automatic model_step();
    bit ft, yr;
    int hvx, hvy, nvx, nvy, nx, ny, cen;
    ft   = bus.vsync && !m_vs;
    m_b  = 0;
    m_gl = 0;
    m_gr = 0;
    if (reset) begin
      m_state = 0; m_x = XHome; m_y = YHome; m_vx = 0; m_vy = 0;
      m_pend = 0; m_cnt = 0; m_vs = 0;
      return;
    end
    m_vs = bus.vsync;
    hvx  = clampv(bus.hit_vx);
    hvy  = clampv(bus.hit_vy);
    if (m_state == 0) begin
      if (ft && bus.serve) begin
        m_state = 1;
        m_vx = bus.serve_dir ? 4 : -4;
        m_vy = 0;
      end
    end else if (m_state == 1) begin
      if (ft) begin
        nvx = bus.hit ? hvx : (m_pend ? m_pvx : m_vx);
        nvy = bus.hit ? hvy : (m_pend ? m_pvy : m_vy);
        m_pend = 0;
        nx = m_x + nvx;
        ny = m_y + nvy;
        yr = 0;
        if (ny < 0) begin ny = 0; nvy = -nvy; yr = 1; end
        else if (ny > YLim) begin ny = YLim; nvy = -nvy; yr = 1; end
        if (nx < 0 || nx > XLim) begin
          cen = ny + 16;
          if (cen >= 256 && cen <= 511) begin
            m_state = 2; m_cnt = 0; m_vx = 0; m_vy = 0;
            if (nx < 0) m_gl = 1; else m_gr = 1;
          end else begin
            m_x = (nx < 0) ? 0 : XLim; m_vx = -nvx; m_y = ny; m_vy = nvy; m_b = 1;
          end
        end else begin
          m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy; m_b = yr;
        end
      end else if (bus.hit) begin
        m_pend = 1; m_pvx = hvx; m_pvy = hvy;
      end
    end else begin
      if (ft) begin
        m_cnt++;
        if (m_cnt == 60) begin m_state = 0; m_x = XHome; m_y = YHome; m_cnt = 0; end
      end
    end
  endtask

  function automatic logic [36:0] dut_vec();
    return {bus.x, bus.y, bus.vx, bus.vy, bus.moving, bus.bounce, bus.goal_left, bus.goal_right};
  endfunction

  function automatic logic [36:0] model_vec();
    return {11'(m_x), 10'(m_y), 6'(m_vx), 6'(m_vy), m_state == 1, m_b, m_gl, m_gr};
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    chk("cycle", 64'(dut_vec()), 64'(model_vec()));
  endtask

  task automatic gap(input int n);
    repeat (n) cyc();
  endtask

  task automatic ft_cyc();
    bus.vsync = 1'b1;
    cyc();
    bus.vsync = 1'b0;
    bus.hit   = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      ft_cyc();
      gap(2);
    end
  endtask

  task automatic hit_now(input int vx, input int vy);
    bus.hit = 1'b1; bus.hit_vx = 6'(vx); bus.hit_vy = 6'(vy);
    cyc();
    bus.hit = 1'b0;
  endtask

  task automatic hit_ft(input int vx, input int vy);
    bus.hit = 1'b1; bus.hit_vx = 6'(vx); bus.hit_vy = 6'(vy);
    ft_cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gap(2);
    reset = 1'b0;
  endtask

  task automatic serve_go(input bit dir);
    bus.serve = 1'b1; bus.serve_dir = dir;
    ft_cyc();
    bus.serve = 1'b0;
    gap(2);
  endtask

  task automatic reach_goal();
    do_reset();
    serve_go(1'b0);
    hit_now(-14, -4);
    frames(17);
    hit_now(-14, 0);
    frames(18);
    hit_now(-4, 0);
    frames(1);
    hit_ft(-5, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.vsync = 1'b0; bus.hit = 1'b0; bus.hit_vx = '0; bus.hit_vy = '0;
    bus.serve = 1'b0; bus.serve_dir = 1'b0;

    // Reset state and serve to the right.
    do_reset();
    chk("rst_x", bus.x, 496);
    chk("rst_y", bus.y, 368);
    chk("rst_v", {bus.vx, bus.vy}, 0);
    chk("rst_moving", bus.moving, 0);
    bus.serve = 1'b1; bus.serve_dir = 1'b1;
    ft_cyc();
    chk("serve_x", bus.x, 496);
    chk("serve_vx", sv(bus.vx), 4);
    chk("serve_moving", bus.moving, 1);
    gap(2);
    ft_cyc();
    chk("tick2_x", bus.x, 500);
    gap(2);
    ft_cyc();
    chk("tick3_x", bus.x, 504);
    bus.serve = 1'b0;
    gap(2);

    // Strike clamping.
    hit_now(31, -20);
    gap(1);
    ft_cyc();
    chk("clamp_vx", sv(bus.vx), 15);
    chk("clamp_vy", sv(bus.vy), -15);
    chk("clamp_x", bus.x, 519);
    chk("clamp_y", bus.y, 353);
    gap(2);

    // Same-cycle strike overrides an older pending one, and the slot is consumed.
    hit_now(3, 3);
    gap(1);
    hit_ft(-7, 2);
    chk("samecyc_vx", sv(bus.vx), -7);
    chk("samecyc_vy", sv(bus.vy), 2);
    chk("samecyc_x", bus.x, 512);
    gap(2);
    ft_cyc();
    chk("slot_cleared_x", bus.x, 505);
    chk("slot_cleared_y", bus.y, 357);
    gap(2);

    // Top wall reflection.
    do_reset();
    serve_go(1'b1);
    hit_now(0, -15);
    frames(24);
    chk("top_pre_y", bus.y, 8);
    hit_now(0, -4);
    frames(1);
    chk("top_y4", bus.y, 4);
    hit_ft(0, -6);
    chk("top_y", bus.y, 0);
    chk("top_vy", sv(bus.vy), 6);
    chk("top_bounce", bus.bounce, 1);
    cyc();
    chk("top_bounce_pulse", bus.bounce, 0);
    gap(2);

    // Left wall outside the goal mouth.
    do_reset();
    serve_go(1'b0);
    hit_now(-14, -14);
    frames(12);
    hit_now(-14, 0);
    frames(23);
    hit_now(-4, 0);
    frames(1);
    chk("left_pre_x", bus.x, 2);
    chk("left_pre_y", bus.y, 200);
    hit_ft(-5, 0);
    chk("left_x", bus.x, 0);
    chk("left_vx", sv(bus.vx), 5);
    chk("left_bounce", bus.bounce, 1);
    chk("left_nogoal", bus.goal_left, 0);
    chk("left_moving", bus.moving, 1);
    gap(2);

    // Left goal, hold, re-centre.
    reach_goal();
    chk("goal_pulse", bus.goal_left, 1);
    chk("goal_moving", bus.moving, 0);
    chk("goal_freeze", {bus.x, bus.y}, {11'd2, 10'd300});
    chk("goal_v", {bus.vx, bus.vy}, 0);
    cyc();
    chk("goal_pulse_end", bus.goal_left, 0);
    gap(1);
    frames(59);
    chk("goal_hold_x", bus.x, 2);
    frames(1);
    chk("recentre", {bus.x, bus.y}, {11'd496, 10'd368});
    serve_go(1'b1);
    chk("idle_after_goal", bus.moving, 1);

    // Reset in the middle of GOAL.
    reach_goal();
    frames(10);
    reset = 1'b1;
    cyc();
    chk("midgoal_rst_pos", {bus.x, bus.y}, {11'd496, 10'd368});
    chk("midgoal_rst_pulse", {bus.goal_left, bus.goal_right}, 0);
    chk("midgoal_rst_moving", bus.moving, 0);
    reset = 1'b0;
    serve_go(1'b0);
    chk("midgoal_serve_vx", sv(bus.vx), -4);

    // Random play.
    for (int i = 0; i < 6000; i++) begin
      bus.vsync     = ($urandom_range(0, 3) == 0);
      bus.hit       = ($urandom_range(0, 9) == 0);
      bus.hit_vx    = 6'($urandom);
      bus.hit_vy    = 6'($urandom);
      bus.serve     = ($urandom_range(0, 3) == 0);
      bus.serve_dir = 1'($urandom);
      reset         = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
